sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter NCH, default 2: number of bus master channels, range 1..4.
REQ-002 Parameter AW, default 21: word address width.
REQ-003 Parameter DW, default 16: data width, multiple of 8; NB = DW/8 byte lanes.
REQ-004 Parameter RSTDLY, default 3: clk_p cycles between sys_reset release and ctl_rst_n release.
REQ-005 clk_p  in  1  sole clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 sys_reset  in  1  system reset request, active high, asynchronous to logic (synchronised internally).
REQ-008 wb_stb  in  NCH  per-channel transaction strobe.
REQ-009 wb_we  in  NCH  per-channel write enable.
REQ-010 wb_sel  in  NCH*NB  per-channel byte selects; channel i at [i*NB +: NB].
REQ-011 wb_adr  in  NCH*AW  per-channel word addresses.
REQ-012 wb_dat_i  in  NCH*DW  per-channel write data.
REQ-013 wb_ack  out  NCH  per-channel transaction acknowledge.
REQ-014 wb_dat_o  out  DW  read data, shared by all channels.
REQ-015 ctl_rst_n  out  1  delayed reset to SDRAM controller, active low.
REQ-016 ctl_wr_req / ctl_rd_req  out  1 each  controller write/read requests.
REQ-017 ctl_wr_ack / ctl_rd_ack  in  1 each  controller one-cycle completion pulses.
REQ-018 ctl_addr  out  AW; ctl_wdata  out  DW; ctl_dqm  out  NB (1 = lane masked).
REQ-019 ctl_rdata  in  DW; ctl_ready  in  1  controller initialisation done.

Function
REQ-020 sys_reset SHALL pass a 2-flop synchroniser; while synchronised value is 1, ctl_rst_n = 0 and delay counter = 0; after release the counter SHALL count to RSTDLY, then ctl_rst_n = 1 on the following cycle.
REQ-021 FSM states IDLE, REQ, REPLY.
REQ-022 IDLE: when ctl_ready = 1, ctl_rst_n = 1, sync reset inactive and any wb_stb set, grant the first requesting channel after the last granted one (round-robin, search wraps NCH-1 -> 0; after reset search starts at channel 0); latch adr, we, wdata; go to REQ next cycle.
REQ-023 ctl_dqm SHALL latch at grant: read -> all 0; write -> ~sel of granted channel.
REQ-024 REQ: ctl_wr_req = we, ctl_rd_req = ~we, held until matching ack pulse; other ack type ignored.
REQ-025 On ctl_rd_ack, ctl_rdata SHALL be registered into wb_dat_o; wb_dat_o holds until next read completes.
REQ-026 On matching ack: requests drop the same cycle (combinational from ack); REPLY next cycle.
REQ-027 wb_ack[g] = (state == REPLY) & wb_stb[g]; all other wb_ack bits 0 always.
REQ-028 REPLY: when wb_stb[g] = 0, go to IDLE next cycle; back-to-back grant earliest one cycle later.
REQ-029 Latency: stb at cycle 0 in IDLE, controller ack at cycle k -> wb_ack at cycle k+1.
REQ-030 Granted strobe dropped during REQ: controller transfer completes, no wb_ack, REPLY exits to IDLE immediately.
REQ-031 Synchronised sys_reset high in any state: return to IDLE next cycle, requests and wb_ack 0, rdata kept.
REQ-032 Non-granted strobes SHALL wait without loss; at most NCH-1 transactions precede any waiting channel.

Reset
REQ-033 rst_n low: state IDLE, ctl_rst_n 0, requests 0, wb_ack 0, wb_dat_o 0, ctl_dqm 0, counter 0, round-robin pointer -> channel 0 first, synchroniser flops 1.

Structure
REQ-034 State encoding and NCH range limit in shared package dvk_sdram_pkg.
REQ-035 One sub-module natural: sdram_rr_arbiter (round-robin grant, NCH-wide one-hot out).

Verification
REQ-036 Release sys_reset, RSTDLY=3 -> ctl_rst_n rises exactly 2+3+1 cycles after release.
REQ-037 Ch0 write adr 0x12345, sel 2'b10, data 0xA55A; ctl_wr_ack at cycle 4 -> ctl_dqm 2'b01, wb_ack[0] at cycle 5, clears the cycle after stb drop.
REQ-038 Ch1 read, ctl_rdata 0xBEEF on ctl_rd_ack -> wb_dat_o 0xBEEF, dqm 2'b00, wb_ack[1] only.
REQ-039 Both strobes continuously high, 6 transactions -> grant order 0,1,0,1,0,1.
REQ-040 Ch0 drops stb in REQ -> no wb_ack, FSM IDLE one cycle after ctl ack; sys_reset pulse mid-REQ -> requests 0 next-but-synchroniser cycle, ctl_rst_n low.

Source files
------------

// File: rtl/dvk_sdram_pkg.sv
// Shared definitions for the SDRAM bus-master arbiter: FSM encoding, channel
// count limits and an index-width helper.
package dvk_sdram_pkg;

  localparam int NCH_MIN = 1;
  localparam int NCH_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_REPLY = 2'd2
  } arb_state_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_rr_arbiter.sv
// Round-robin grant: picks the first requester after the last granted channel,
// wrapping from NCH-1 back to 0.
module sdram_rr_arbiter
  import dvk_sdram_pkg::*;
#(
  parameter int  NCH = 2,
  localparam int IW  = idx_width(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [IW-1:0]  last_i,
  output logic [NCH-1:0] gnt_o,
  output logic [IW-1:0]  gnt_idx_o
);

  int   idx;
  logic found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(last_i) + k) % NCH;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Multi-channel Wishbone-style front end for a single SDRAM controller:
// reset sequencing, round-robin channel grant and one outstanding transfer.
module sdram_arbiter
  import dvk_sdram_pkg::*;
#(
  parameter int  NCH    = 2,
  parameter int  AW     = 21,
  parameter int  DW     = 16,
  parameter int  RSTDLY = 3,
  localparam int NB     = DW / 8,
  localparam int IW     = idx_width(NCH)
) (
  input  logic              clk_p,
  input  logic              rst_n,
  input  logic              sys_reset,
  input  logic [NCH-1:0]    wb_stb,
  input  logic [NCH-1:0]    wb_we,
  input  logic [NCH*NB-1:0] wb_sel,
  input  logic [NCH*AW-1:0] wb_adr,
  input  logic [NCH*DW-1:0] wb_dat_i,
  output logic [NCH-1:0]    wb_ack,
  output logic [DW-1:0]     wb_dat_o,
  output logic              ctl_rst_n,
  output logic              ctl_wr_req,
  output logic              ctl_rd_req,
  input  logic              ctl_wr_ack,
  input  logic              ctl_rd_ack,
  output logic [AW-1:0]     ctl_addr,
  output logic [DW-1:0]     ctl_wdata,
  output logic [NB-1:0]     ctl_dqm,
  input  logic [DW-1:0]     ctl_rdata,
  input  logic              ctl_ready,
  output arb_state_e        dbg_state_o
);

  localparam int CW = (RSTDLY > 0) ? $clog2(RSTDLY + 1) : 1;

  logic [1:0]     sync_q;
  logic           sys_rst_s;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           crst_q, crst_d;
  arb_state_e     state_q, state_d;
  logic [NCH-1:0] gnt_q, gnt_d;
  logic [IW-1:0]  last_q, last_d;
  logic           we_q, we_d;
  logic [AW-1:0]  adr_q, adr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [NB-1:0]  dqm_q, dqm_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           wr_req, rd_req, done;
  logic [NCH-1:0] arb_gnt;
  logic [IW-1:0]  arb_idx;
  logic [NB-1:0]  sel_g;

  assign sys_rst_s = sync_q[1];

  sdram_rr_arbiter #(.NCH(NCH)) u_rr (
    .req_i     (wb_stb),
    .last_i    (last_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  assign sel_g = wb_sel[arb_idx*NB +: NB];

  // Controller release: counter runs only once the synchronised request is low.
  always_comb begin
    cnt_d  = cnt_q;
    crst_d = crst_q;
    if (sys_rst_s) begin
      cnt_d  = '0;
      crst_d = 1'b0;
    end else if (cnt_q != CW'(RSTDLY)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      crst_d = 1'b1;
    end
  end

  // Controller handshake: a request stays high until its matching one-cycle ack,
  // and falls in that same cycle so the controller never sees a second request.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    dqm_d   = dqm_q;
    rdata_d = rdata_q;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    done    = we_q ? ctl_wr_ack : ctl_rd_ack;
    case (state_q)
      ST_IDLE: begin
        if (ctl_ready && crst_q && !sys_rst_s && (|wb_stb)) begin
          state_d = ST_REQ;
          gnt_d   = arb_gnt;
          last_d  = arb_idx;
          we_d    = wb_we[arb_idx];
          adr_d   = wb_adr[arb_idx*AW +: AW];
          wdata_d = wb_dat_i[arb_idx*DW +: DW];
          dqm_d   = wb_we[arb_idx] ? ~sel_g : '0;
        end
      end
      ST_REQ: begin
        wr_req = we_q & ~ctl_wr_ack;
        rd_req = ~we_q & ~ctl_rd_ack;
        if (done) begin
          state_d = ST_REPLY;
          if (!we_q) rdata_d = ctl_rdata;
        end
      end
      ST_REPLY: begin
        if (!(|(gnt_q & wb_stb))) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (sys_rst_s) begin
      state_d = ST_IDLE;
      wr_req  = 1'b0;
      rd_req  = 1'b0;
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      crst_q  <= 1'b0;
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NCH - 1);
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
      dqm_q   <= '0;
      rdata_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], sys_reset};
      cnt_q   <= cnt_d;
      crst_q  <= crst_d;
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      dqm_q   <= dqm_d;
      rdata_q <= rdata_d;
    end
  end

  assign wb_ack      = (state_q == ST_REPLY && !sys_rst_s) ? (gnt_q & wb_stb) : '0;
  assign wb_dat_o    = rdata_q;
  assign ctl_rst_n   = crst_q;
  assign ctl_wr_req  = wr_req;
  assign ctl_rd_req  = rd_req;
  assign ctl_addr    = adr_q;
  assign ctl_wdata   = wdata_q;
  assign ctl_dqm     = dqm_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: reset sequencing, single transfers, strobe drop,
// sys_reset during a transfer and round-robin ordering.
module tb_sdram_arbiter;
  import dvk_sdram_pkg::*;

  localparam int NCH = 2;
  localparam int AW  = 21;
  localparam int DW  = 16;
  localparam int RSTDLY = 3;
  localparam int NB  = DW / 8;
  localparam int EW  = 1 + AW + DW + NB;

  logic              clk_p = 1'b0;
  logic              rst_n;
  logic              sys_reset;
  logic [NCH-1:0]    wb_stb;
  logic [NCH-1:0]    wb_we;
  logic [NCH*NB-1:0] wb_sel;
  logic [NCH*AW-1:0] wb_adr;
  logic [NCH*DW-1:0] wb_dat_i;
  logic [NCH-1:0]    wb_ack;
  logic [DW-1:0]     wb_dat_o;
  logic              ctl_rst_n, ctl_wr_req, ctl_rd_req;
  logic              ctl_wr_ack, ctl_rd_ack;
  logic [AW-1:0]     ctl_addr;
  logic [DW-1:0]     ctl_wdata;
  logic [NB-1:0]     ctl_dqm;
  logic [DW-1:0]     ctl_rdata;
  logic              ctl_ready;
  arb_state_e        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;
  int ack_cyc = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] last_rd = '0;
  bit            ch_we[NCH];

  sdram_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RSTDLY(RSTDLY)) dut (
    .clk_p(clk_p), .rst_n(rst_n), .sys_reset(sys_reset),
    .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel), .wb_adr(wb_adr),
    .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_dat_o(wb_dat_o),
    .ctl_rst_n(ctl_rst_n), .ctl_wr_req(ctl_wr_req), .ctl_rd_req(ctl_rd_req),
    .ctl_wr_ack(ctl_wr_ack), .ctl_rd_ack(ctl_rd_ack), .ctl_addr(ctl_addr),
    .ctl_wdata(ctl_wdata), .ctl_dqm(ctl_dqm), .ctl_rdata(ctl_rdata),
    .ctl_ready(ctl_ready), .dbg_state_o(dbg_state)
  );

  // clock / cycle counter
  always #5 clk_p = ~clk_p;
  always @(posedge clk_p) cyc_n <= cyc_n + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_p);
    #1;
  endtask

  // master driver: raise a channel strobe and record the expected controller command
  task automatic issue(input int ch, input bit we, input logic [AW-1:0] adr,
                       input logic [NB-1:0] sel, input logic [DW-1:0] dat);
    logic [NB-1:0] dqm;
    wb_stb[ch]             = 1'b1;
    wb_we[ch]              = we;
    wb_sel[ch*NB +: NB]    = sel;
    wb_adr[ch*AW +: AW]    = adr;
    wb_dat_i[ch*DW +: DW]  = dat;
    ch_we[ch]              = we;
    dqm = we ? ~sel : {NB{1'b0}};
    exp_q.push_back({we, adr, dat, dqm});
  endtask

  // controller driver: wait for a request, compare it, then ack after lat cycles
  task automatic serve(input int lat, input logic [DW-1:0] rdata);
    int n;
    bit is_wr;
    logic [EW-1:0] e;
    n = 0;
    @(negedge clk_p);
    while (!(ctl_wr_req || ctl_rd_req) && n < 30) begin
      @(negedge clk_p);
      n++;
    end
    if (n >= 30) begin
      check("ctl_req_timeout", 0, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 0, 1);
      return;
    end
    is_wr = ctl_wr_req;
    e = exp_q.pop_front();
    check("ctl_cmd", {ctl_wr_req, ctl_addr, ctl_wdata, ctl_dqm}, e);
    check("ctl_req_excl", ctl_rd_req, !is_wr);
    for (int i = 1; i < lat; i++) begin
      cyc();
      if (is_wr) ctl_rd_ack = (i == 1);
      else       ctl_wr_ack = (i == 1);
      @(negedge clk_p);
      check("ctl_req_held", is_wr ? ctl_wr_req : ctl_rd_req, 1);
    end
    cyc();
    ctl_wr_ack = 1'b0;
    ctl_rd_ack = 1'b0;
    if (is_wr) ctl_wr_ack = 1'b1;
    else begin
      ctl_rd_ack = 1'b1;
      ctl_rdata  = rdata;
      rd_q.push_back(rdata);
    end
    ack_cyc = cyc_n;
    @(negedge clk_p);
    check("ctl_req_drop", {ctl_wr_req, ctl_rd_req}, 0);
    check("wb_ack_early", wb_ack, 0);
    cyc();
    ctl_wr_ack = 1'b0;
    ctl_rd_ack = 1'b0;
    ctl_rdata  = ~rdata;
  endtask

  // master completion: expect ack on channel ch one cycle after the controller ack
  task automatic reply(input int ch);
    logic [NCH-1:0] onehot;
    logic [DW-1:0]  e;
    onehot = '0;
    onehot[ch] = 1'b1;
    @(negedge clk_p);
    check("wb_ack", wb_ack, onehot);
    check("wb_ack_latency", cyc_n, ack_cyc + 1);
    if (!ch_we[ch]) begin
      if (rd_q.size() == 0) check("rd_q_empty", 0, 1);
      else begin
        e = rd_q.pop_front();
        check("wb_dat_o", wb_dat_o, e);
        last_rd = e;
      end
    end else begin
      check("rdata_hold", wb_dat_o, last_rd);
    end
    cyc();
    wb_stb[ch] = 1'b0;
    @(negedge clk_p);
    check("wb_ack_clear", wb_ack, 0);
  endtask

  initial begin
    int n;
    int t0;
    logic [EW-1:0] e;
    rst_n = 1'b0; sys_reset = 1'b1;
    wb_stb = '0; wb_we = '0; wb_sel = '0; wb_adr = '0; wb_dat_i = '0;
    ctl_wr_ack = 1'b0; ctl_rd_ack = 1'b0; ctl_rdata = '0; ctl_ready = 1'b0;
    repeat (2) @(negedge clk_p);
    check("rst_ctl_rst_n", ctl_rst_n, 0);
    check("rst_reqs", {ctl_wr_req, ctl_rd_req}, 0);
    check("rst_wb_ack", wb_ack, 0);
    check("rst_wb_dat_o", wb_dat_o, 0);
    check("rst_dqm", ctl_dqm, 0);
    check("rst_state", dbg_state, ST_IDLE);
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    check("sysrst_hold", ctl_rst_n, 0);

    // reset release delay: 2 sync + RSTDLY count + 1
    sys_reset = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (ctl_rst_n) begin
        n = i;
        break;
      end
    end
    check("rst_release_cycles", n, 2 + RSTDLY + 1);

    // no grant while controller not ready
    issue(0, 1'b1, 21'h1, 2'b00, 16'h1);
    repeat (3) cyc();
    @(negedge clk_p);
    check("no_grant_unready", dbg_state, ST_IDLE);
    wb_stb[0] = 1'b0;
    void'(exp_q.pop_back());
    ctl_ready = 1'b1;

    // ch0 write, ack at cycle 4, wb_ack at cycle 5
    cyc();
    t0 = cyc_n;
    issue(0, 1'b1, 21'h12345, 2'b10, 16'hA55A);
    serve(3, 16'h0);
    check("wr_ack_cycle", ack_cyc - t0, 4);
    reply(0);

    // ch1 read returning 0xBEEF
    cyc();
    issue(1, 1'b0, 21'h00ABC, 2'b11, 16'h0);
    serve(2, 16'hBEEF);
    reply(1);
    check("rd_wb_dat_o", wb_dat_o, 16'hBEEF);

    // ch0 drops its strobe while the controller is busy
    cyc();
    issue(0, 1'b1, 21'h00777, 2'b00, 16'h7777);
    cyc();
    @(negedge clk_p);
    check("drop_in_req", dbg_state, ST_REQ);
    cyc();
    wb_stb[0] = 1'b0;
    serve(2, 16'h0);
    @(negedge clk_p);
    check("drop_no_ack", wb_ack, 0);
    check("drop_left_req", dbg_state != ST_REQ, 1);
    cyc();
    @(negedge clk_p);
    check("drop_idle", dbg_state, ST_IDLE);
    check("drop_no_ack2", wb_ack, 0);

    // one-cycle sys_reset pulse while ch1 write is in REQ
    cyc();
    issue(1, 1'b1, 21'h00555, 2'b01, 16'h5555);
    cyc();
    @(negedge clk_p);
    e = exp_q.pop_front();
    check("sr_cmd", {ctl_wr_req, ctl_addr, ctl_wdata, ctl_dqm}, e);
    cyc();
    sys_reset = 1'b1;
    cyc();
    sys_reset = 1'b0;
    @(negedge clk_p);
    check("sr_sync_delay", ctl_wr_req, 1);
    cyc();
    @(negedge clk_p);
    check("sr_reqs_low", {ctl_wr_req, ctl_rd_req}, 0);
    check("sr_no_ack", wb_ack, 0);
    cyc();
    @(negedge clk_p);
    check("sr_state_idle", dbg_state, ST_IDLE);
    check("sr_ctl_rst_n", ctl_rst_n, 0);
    check("sr_rdata_kept", wb_dat_o, last_rd);
    wb_stb[1] = 1'b0;
    n = 0;
    while (!ctl_rst_n && n < 20) begin
      cyc();
      n++;
    end
    check("sr_rst_n_back", ctl_rst_n, 1);

    // both channels busy: grants alternate starting with ch0
    cyc();
    issue(0, 1'($urandom_range(0, 1)), AW'(21'h1000), NB'($urandom_range(0, 3)), DW'($urandom_range(0, 65535)));
    issue(1, 1'($urandom_range(0, 1)), AW'(21'h1001), NB'($urandom_range(0, 3)), DW'($urandom_range(0, 65535)));
    for (int i = 0; i < 6; i++) begin
      serve($urandom_range(1, 3), DW'($urandom_range(0, 65535)));
      reply(i % 2);
      if (i + 2 < 6) begin
        cyc();
        issue(i % 2, 1'($urandom_range(0, 1)), AW'(21'h1000 + i + 2),
              NB'($urandom_range(0, 3)), DW'($urandom_range(0, 65535)));
      end
    end
    check("exp_q_drained", exp_q.size(), 0);

    repeat (2) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
